// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage bridge to a 4096x32 data RAM.
// Performs sub-word loads/stores via read-modify-write, plus alignment checks.
// Optional macro DMEM_ALIGN_CHECK_EN enables misalignment exceptions.
// When it is undefined, addresses are force-aligned and size 11 acts as word.
// Ports:
//   clk, reset (sync, active-high)
//   req_valid/req_ready, req_write, req_size, req_signed, req_addr, req_wdata
//   resp_valid, resp_rdata, exception
//   ram_re, ram_we, ram_addr, ram_wdata, ram_rdata
module dmem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exception,
  output logic        ram_re,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t      state;
  state_t      state_nxt;

  logic [13:0] q_addr;
  logic [1:0]  q_size;
  logic        q_signed;
  logic        q_write;
  logic [31:0] q_wdata;
  logic [31:0] q_word;

  logic        accept;
  logic        misalign;
  logic [1:0]  eff_size;
  logic [13:0] eff_addr;

  // Extract a byte/half/word from a RAM word and extend it.
  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  off,
    input logic [1:0]  sz,
    input logic        sg
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    unique case (1'b1)
      (sz == SZ_B): r = {{24{sg & b[7]}}, b};
      (sz == SZ_H): r = {{16{sg & h[15]}}, h};
      default:      r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] store_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  off,
    input logic [1:0]  sz
  );
    logic [31:0] mask;
    logic [31:0] data;
    unique case (1'b1)
      (sz == SZ_B): begin
        mask = 32'h0000_00ff << {off, 3'b000};
        data = {4{wd[7:0]}};
      end
      (sz == SZ_H): begin
        mask = off[1] ? 32'hffff_0000 : 32'h0000_ffff;
        data = {2{wd[15:0]}};
      end
      default: begin
        mask = 32'hffff_ffff;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    eff_size = req_size;
    eff_addr = req_addr;
    misalign = (req_size == 2'b11)
             | ((req_size == SZ_H) & req_addr[0])
             | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));
  end
`else
  // No exception path: size 11 is treated as word and the
  // low address bits are simply dropped for half/word.
  always_comb begin
    eff_size = (req_size == 2'b11) ? SZ_W : req_size;
    eff_addr = req_addr;
    misalign = 1'b0;
    unique case (1'b1)
      (eff_size == SZ_H): eff_addr = {req_addr[13:1], 1'b0};
      (eff_size == SZ_W): eff_addr = {req_addr[13:2], 2'b00};
      default:            eff_addr = req_addr;
    endcase
  end
`endif

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    resp_valid = 1'b0;
    ram_addr   = q_addr;
    ram_wdata  = store_merge(q_word, q_wdata, q_addr[1:0], q_size);
    unique case (state)
      IDLE: begin
        req_ready = ~reset;
        if (accept) begin
          if (misalign)             state_nxt = RESP;
          else if (!req_write)      state_nxt = READ;
          else if (eff_size == SZ_W) state_nxt = WRITE;
          else                      state_nxt = READ;
        end
      end
      READ: begin
        ram_re    = ~reset;
        state_nxt = q_write ? WRITE : RESP;
      end
      WRITE: begin
        ram_we    = ~reset;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response registers only change on entry to RESP, so they hold
  // their value from one resp_valid pulse to the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_addr     <= '0;
      q_size     <= '0;
      q_signed   <= 1'b0;
      q_write    <= 1'b0;
      q_wdata    <= '0;
      q_word     <= '0;
      resp_rdata <= '0;
      exception  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            q_addr   <= eff_addr;
            q_size   <= eff_size;
            q_signed <= req_signed;
            q_write  <= req_write;
            q_wdata  <= req_wdata;
            if (misalign) begin
              resp_rdata <= '0;
              exception  <= 1'b1;
            end
          end
        end
        READ: begin
          q_word <= ram_rdata;
          if (!q_write) begin
            resp_rdata <= load_ext(ram_rdata, q_addr[1:0],
                                   q_size, q_signed);
            exception  <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          exception  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench for dmem_access_unit.
// Models the RAM behaviourally and checks latency, data and lane handling.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exception;
  logic        ram_re;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:4095];
  int tests = 0;
  int fails = 0;

  dmem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .exception  (exception),
    .ram_re     (ram_re),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr[13:2]];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[13:2]] <= ram_wdata;
  end

  // Issue one request and observe the 8 cycles after the accept edge.
  // lat stays -1 if no resp_valid shows up within that window.
  task automatic access(
    input  logic        w,
    input  logic [1:0]  sz,
    input  logic        sg,
    input  logic [13:0] a,
    input  logic [31:0] wd,
    output int          lat,
    output logic [31:0] rd,
    output logic        ex,
    output int          nwe,
    output int          nre
  );
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    rd  = 'x;
    ex  = 1'bx;
    nwe = 0;
    nre = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ram_we) nwe++;
      if (ram_re) nre++;
      if (resp_valid && lat < 0) begin
        lat = c;
        rd  = resp_rdata;
        ex  = exception;
      end
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready got %b want 0", req_ready);
    end
    tests++;
    if ({resp_valid, exception, ram_re, ram_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctl got %b want 0000",
               {resp_valid, exception, ram_re, ram_we});
    end
    tests++;
    if (resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata got %h want 0", resp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_word;
    int lat, nwe, nre;
    logic [31:0] rd;
    logic ex;
    access(1'b1, 2'b10, 1'b0, 14'h010, 32'hdeadbeef,
           lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 2 || nwe !== 1 || nre !== 0) begin
      fails++;
      $display("FAIL wstore_timing got lat=%0d we=%0d re=%0d want 2/1/0",
               lat, nwe, nre);
    end
    tests++;
    if (mem[4] !== 32'hdeadbeef || rd !== 32'h0) begin
      fails++;
      $display("FAIL wstore_data got mem=%h rd=%h want deadbeef/0",
               mem[4], rd);
    end
    access(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,
           lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 2 || nre !== 1 || nwe !== 0) begin
      fails++;
      $display("FAIL wload_timing got lat=%0d re=%0d we=%0d want 2/1/0",
               lat, nre, nwe);
    end
    tests++;
    if (rd !== 32'hdeadbeef || ex !== 1'b0) begin
      fails++;
      $display("FAIL wload_data got %h ex=%b want deadbeef ex=0", rd, ex);
    end
  endtask

  task automatic test_subword_store;
    int lat, nwe, nre;
    logic [31:0] rd;
    logic ex;
    access(1'b1, 2'b00, 1'b0, 14'h012, 32'h0000005a,
           lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 3 || nwe !== 1 || nre !== 1) begin
      fails++;
      $display("FAIL bstore_timing got lat=%0d we=%0d re=%0d want 3/1/1",
               lat, nwe, nre);
    end
    tests++;
    if (mem[4] !== 32'hde5abeef) begin
      fails++;
      $display("FAIL bstore_data got %h want de5abeef", mem[4]);
    end
    access(1'b1, 2'b01, 1'b0, 14'h026, 32'h1234cafe,
           lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 3 || mem[9] !== 32'hcafe0000) begin
      fails++;
      $display("FAIL hstore got lat=%0d mem=%h want 3 cafe0000",
               lat, mem[9]);
    end
  endtask

  task automatic test_loads;
    int lat, nwe, nre;
    logic [31:0] rd;
    logic ex;
    access(1'b0, 2'b00, 1'b1, 14'h013, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'hffffffde || lat !== 2) begin
      fails++;
      $display("FAIL lb_s_013 got %h lat=%0d want ffffffde 2", rd, lat);
    end
    access(1'b0, 2'b00, 1'b0, 14'h013, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'h000000de) begin
      fails++;
      $display("FAIL lb_u_013 got %h want 000000de", rd);
    end
    access(1'b0, 2'b01, 1'b1, 14'h012, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'hffffde5a) begin
      fails++;
      $display("FAIL lh_s_012 got %h want ffffde5a", rd);
    end
    access(1'b0, 2'b01, 1'b0, 14'h010, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'h0000beef) begin
      fails++;
      $display("FAIL lh_u_010 got %h want 0000beef", rd);
    end
    access(1'b0, 2'b00, 1'b1, 14'h010, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'hffffffef) begin
      fails++;
      $display("FAIL lb_s_010 got %h want ffffffef", rd);
    end
    access(1'b0, 2'b00, 1'b1, 14'h012, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'h0000005a) begin
      fails++;
      $display("FAIL lb_s_012 got %h want 0000005a", rd);
    end
    access(1'b0, 2'b01, 1'b1, 14'h026, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'hffffcafe) begin
      fails++;
      $display("FAIL lh_s_026 got %h want ffffcafe", rd);
    end
    access(1'b0, 2'b00, 1'b0, 14'h011, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (rd !== 32'h000000be) begin
      fails++;
      $display("FAIL lb_u_011 got %h want 000000be", rd);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (resp_rdata !== 32'h000000be || exception !== 1'b0) begin
      fails++;
      $display("FAIL resp_hold got %h ex=%b want 000000be 0",
               resp_rdata, exception);
    end
  endtask

  task automatic test_misalign;
    int lat, nwe, nre;
    logic [31:0] rd;
    logic ex;
`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b0, 2'b10, 1'b0, 14'h011, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 1 || ex !== 1'b1 || rd !== 32'h0 ||
        nre !== 0 || nwe !== 0) begin
      fails++;
      $display("FAIL mis_lw got lat=%0d ex=%b rd=%h re=%0d we=%0d",
               lat, ex, rd, nre, nwe);
    end
    access(1'b1, 2'b01, 1'b0, 14'h013, 32'h0000ffff,
           lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 1 || ex !== 1'b1 || nwe !== 0 ||
        mem[4] !== 32'hde5abeef) begin
      fails++;
      $display("FAIL mis_sh got lat=%0d ex=%b we=%0d mem=%h",
               lat, ex, nwe, mem[4]);
    end
    access(1'b0, 2'b11, 1'b0, 14'h010, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 1 || ex !== 1'b1 || nre !== 0) begin
      fails++;
      $display("FAIL mis_sz11 got lat=%0d ex=%b re=%0d want 1 1 0",
               lat, ex, nre);
    end
`else
    access(1'b0, 2'b10, 1'b0, 14'h011, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 2 || ex !== 1'b0 || rd !== 32'hde5abeef) begin
      fails++;
      $display("FAIL align_lw got lat=%0d ex=%b rd=%h want 2 0 de5abeef",
               lat, ex, rd);
    end
    access(1'b0, 2'b01, 1'b0, 14'h013, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (ex !== 1'b0 || rd !== 32'h0000de5a) begin
      fails++;
      $display("FAIL align_lh got %h ex=%b want 0000de5a 0", rd, ex);
    end
    access(1'b0, 2'b11, 1'b0, 14'h012, 32'h0, lat, rd, ex, nwe, nre);
    tests++;
    if (lat !== 2 || ex !== 1'b0 || rd !== 32'hde5abeef) begin
      fails++;
      $display("FAIL align_sz11 got lat=%0d ex=%b rd=%h want 2 0 de5abeef",
               lat, ex, rd);
    end
`endif
  endtask

  task automatic test_reset_in_write;
    int nresp;
    nresp = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 14'h020;
    req_wdata  = 32'h000000aa;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_write = 1'b0;
    @(negedge clk);
    tests++;
    if (ram_re !== 1'b1) begin
      fails++;
      $display("FAIL rst_wr_read got ram_re=%b want 1", ram_re);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    tests++;
    if (ram_we !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_wr_gate got we=%b rv=%b want 0 0",
               ram_we, resp_valid);
    end
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (resp_valid) nresp++;
    tests++;
    if (req_ready !== 1'b1 || nresp !== 0) begin
      fails++;
      $display("FAIL rst_wr_after got ready=%b resp=%0d want 1 0",
               req_ready, nresp);
    end
    tests++;
    if (mem[8] !== 32'h0 || resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_wr_mem got mem=%h rdata=%h want 0 0",
               mem[8], resp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int nacc, nre, nrv;
    nacc = 0;
    nre  = 0;
    nrv  = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 14'h010;
    for (int i = 0; i < 8; i++) begin
      if (req_valid && req_ready) nacc++;
      if (ram_re) nre++;
      if (resp_valid) nrv++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (nacc !== 3 || nre !== 3 || nrv !== 2) begin
      fails++;
      $display("FAIL b2b_counts got acc=%0d re=%0d rv=%0d want 3 3 2",
               nacc, nre, nrv);
    end
    tests++;
    if (resp_rdata !== 32'hde5abeef) begin
      fails++;
      $display("FAIL b2b_data got %h want de5abeef", resp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    test_reset;
    test_word;
    test_subword_store;
    test_loads;
    test_misalign;
    test_reset_in_write;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
